// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared types and Wishbone constants for the read streamer
package wb_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone classic bus bundle with master and slave views
interface wshb_if #(parameter int dw = 32, parameter int aw = 32) (input logic clk, input logic rst);
  logic cyc, stb, we, ack, err, rty;
  logic [dw/8-1:0] sel;
  logic [aw-1:0] adr;
  logic [dw-1:0] dat_ms, dat_sm;
  logic [2:0] cti;
  logic [1:0] bte;
  modport master (input clk, rst, ack, err, rty, dat_sm, output cyc, stb, we, sel, adr, dat_ms, cti, bte);
  modport slave (input clk, rst, cyc, stb, we, sel, adr, dat_ms, cti, bte, output ack, err, rty, dat_sm);
endinterface

// File: rtl/wb_read_streamer_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count
module sync_fifo #(parameter int width = 32, parameter int depth = 4) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(depth):0] count
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == cw'(depth);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // storage, pointers and occupancy; pop on empty and push on full are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + aw'(do_push);
      rd_ptr <= rd_ptr + aw'(do_pop);
      count <= count + cw'(do_push) - cw'(do_pop);
    end
  end
endmodule

// File: rtl/wb_read_streamer.sv
// wb_read_streamer: Wishbone reader that streams a word window through a FWFT FIFO
module wb_read_streamer import wb_stream_pkg::*; #(
  parameter int fifo_depth = 4,
  parameter int cnt_width = 16
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [31:0] base_adr,
  input logic [cnt_width-1:0] word_count,
  output logic busy,
  output logic done,
  wshb_if.master wb_m,
  output logic [31:0] out_data,
  output logic out_valid,
  input logic out_ready
);
  localparam int cw = $clog2(fifo_depth) + 1;
  state_t state, state_n;
  logic stb_q, stb_n, done_n, ack_hit, pop, room, full, empty;
  logic [31:0] adr_q, adr_n;
  logic [cnt_width-1:0] rem_q, rem_n;
  logic [cw-1:0] count;
  assign ack_hit = stb_q && wb_m.ack;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign busy = state != IDLE;
  assign wb_m.cyc = stb_q;
  assign wb_m.stb = stb_q;
  assign wb_m.we = 1'b0;
  assign wb_m.sel = WB_SEL_ALL;
  assign wb_m.adr = adr_q;
  assign wb_m.dat_ms = '0;
  assign wb_m.cti = WB_CTI_CLASSIC;
  assign wb_m.bte = WB_BTE_LINEAR;
  // space left after this cycle's push/pop; a pop always frees a slot since full never pushes
  assign room = pop ? 1'b1 : ack_hit ? count < cw'(fifo_depth - 1) : !full;
  sync_fifo #(.width(32), .depth(fifo_depth)) u_fifo (
    .clk(clk), .rst(rst), .push(ack_hit), .pop(pop), .din(wb_m.dat_sm),
    .dout(out_data), .full(full), .empty(empty), .count(count)
  );
  // next state, address/counter update and issue decision; stb holds until acked
  always_comb begin
    state_n = state;
    adr_n = adr_q;
    rem_n = rem_q;
    done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && word_count != '0) begin
          state_n = READ;
          adr_n = word_align(base_adr);
          rem_n = word_count;
        end else done_n = start;
      end
      READ: begin
        if (ack_hit) begin
          adr_n = adr_q + WORD_BYTES;
          rem_n = rem_q - cnt_width'(1);
          state_n = rem_q == cnt_width'(1) ? DRAIN : READ;
        end
      end
      DRAIN: begin
        if (pop && count == cw'(1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    stb_n = state_n == READ && ((stb_q && !wb_m.ack) || (rem_n != '0 && room));
  end
  // state register; reset drops the bus request immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stb_q <= 1'b0;
      adr_q <= '0;
      rem_q <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      stb_q <= stb_n;
      adr_q <= adr_n;
      rem_q <= rem_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_wb_read_streamer.sv
// tb_wb_read_streamer: scoreboard bench with a Wishbone memory slave model
module tb_wb_read_streamer;
  logic clk = 0, rst = 1, start = 0, out_ready = 0, rand_rdy = 0;
  logic [31:0] base_adr = 0;
  logic [15:0] word_count = 0;
  logic busy, done, out_valid;
  logic [31:0] out_data;
  wshb_if wb (.clk(clk), .rst(rst));
  wb_read_streamer #(.fifo_depth(4), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .word_count(word_count),
    .busy(busy), .done(done), .wb_m(wb), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction
  int lat = 0, wcnt = 0;
  assign wb.err = 1'b0;
  assign wb.rty = 1'b0;
  // memory slave: ack lat cycles after seeing stb, one-cycle ack, then at least one idle cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.ack <= 1'b0;
      wb.dat_sm <= '0;
      wcnt <= 0;
    end else if (wb.ack) wb.ack <= 1'b0;
    else if (wb.cyc && wb.stb) begin
      if (wcnt >= lat) begin
        wb.ack <= 1'b1;
        wb.dat_sm <= mem_rd(wb.adr);
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end
  end
  // random consumer back-pressure when enabled
  always @(posedge clk) if (rand_rdy) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end
  logic [31:0] exp_adr[$], exp_dat[$];
  int ncyc = 0, acks = 0, dones = 0, exp_done_at = -1;
  logic pv = 0, pr = 0;
  logic [31:0] pd = 0;
  // monitor: bus acks checked against expected addresses, stream against expected data
  always @(negedge clk) begin
    if (rst) pv = 0;
    else begin
      ncyc++;
      if (done) begin
        dones++;
        chk("done_busy", busy, 0);
        if (exp_done_at >= 0) begin
          chk("done_lat", ncyc, exp_done_at);
          exp_done_at = -1;
        end
      end
      chk("cyc_eq_stb", wb.cyc, wb.stb);
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (wb.stb && wb.ack) begin
        acks++;
        if (exp_adr.size() == 0) chk("stray_ack", exp_adr.size(), 1);
        else chk("adr", wb.adr, exp_adr.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_dat.size() == 0) chk("stray_word", exp_dat.size(), 1);
        else begin
          chk("data", out_data, exp_dat.pop_front());
          if (exp_dat.size() == 0) exp_done_at = ncyc + 1;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end
  task automatic go(input logic [31:0] b, input int n, input bit track);
    logic [31:0] a;
    @(posedge clk) #1;
    start = 1;
    base_adr = b;
    word_count = 16'(n);
    if (track) for (int i = 0; i < n; i++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_adr.push_back(a);
      exp_dat.push_back(mem_rd(a));
    end
    @(posedge clk) #1;
    start = 0;
  endtask
  task automatic finish_xfer(input string tag, input int d0);
    for (int i = 0; i < 3000 && (exp_dat.size() != 0 || exp_adr.size() != 0 || busy || dones == d0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_left"}, exp_dat.size() + exp_adr.size(), 0);
    chk({tag, "_dones"}, dones - d0, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask
  int d0, a0;
  initial begin
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_we", wb.we, 0);
    chk("rst_adr", wb.adr, 0);
    chk("sel", wb.sel, 4'hF);
    chk("cti", wb.cti, 0);
    @(negedge clk) rst = 0;
    mem[32'h100] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) mem[32'(4 * i)] = 32'(i) * 32'h1111_1111;
    out_ready = 1;
    d0 = dones; a0 = acks;
    go(32'h100, 1, 1);
    finish_xfer("single", d0);
    chk("single_acks", acks - a0, 1);
    d0 = dones; a0 = acks;
    go(32'h0, 8, 1);
    finish_xfer("burst", d0);
    chk("burst_acks", acks - a0, 8);
    @(posedge clk) #1 out_ready = 0;
    d0 = dones; a0 = acks;
    go(32'h400, 10, 1);
    repeat (30) @(negedge clk);
    chk("bp_acks", acks - a0, 4);
    chk("bp_stb", wb.stb, 0);
    chk("bp_valid", out_valid, 1);
    @(posedge clk) #1 out_ready = 1;
    finish_xfer("bp", d0);
    chk("bp_total_acks", acks - a0, 10);
    d0 = dones;
    @(posedge clk) #1;
    start = 1; base_adr = 32'h700; word_count = 0;
    @(negedge clk) chk("zero_stb", wb.stb, 0);
    @(posedge clk) #1 start = 0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_stb2", wb.stb, 0);
    @(negedge clk) chk("zero_pulse", done, 0);
    chk("zero_dones", dones - d0, 1);
    lat = 1;
    d0 = dones; a0 = acks;
    go(32'h800, 8, 1);
    repeat (5) @(negedge clk);
    chk("busy_mid", busy, 1);
    go(32'h2000, 3, 0);
    finish_xfer("ignore", d0);
    chk("ignore_acks", acks - a0, 8);
    lat = 0;
    d0 = dones;
    go(32'hFFFF_FFF8, 4, 1);
    finish_xfer("wrap", d0);
    d0 = dones;
    go(32'h203, 2, 1);
    finish_xfer("unaligned", d0);
    lat = 2; rand_rdy = 1;
    d0 = dones;
    go(32'h3000, 12, 1);
    finish_xfer("random", d0);
    rand_rdy = 0;
    @(posedge clk) #1 out_ready = 0;
    lat = 3;
    d0 = dones; a0 = acks;
    go(32'h500, 5, 1);
    for (int i = 0; i < 200 && !(acks - a0 == 2 && wb.stb && !wb.ack); i++) @(negedge clk);
    chk("pre_rst_stb", wb.stb, 1);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("mid_rst_stb", wb.stb, 0);
    chk("mid_rst_cyc", wb.cyc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    exp_adr.delete(); exp_dat.delete(); exp_done_at = -1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("rst_no_done", dones - d0, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);
    lat = 0;
    @(posedge clk) #1 out_ready = 1;
    d0 = dones;
    go(32'h600, 3, 1);
    finish_xfer("after_rst", d0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
